shifter_stage: RTL and testbench
================================

# shifter_stage

Registered shifter stage directly downstream of the ALU. It accepts the ALU result and carry-out, applies the microinstruction's shift operation, and presents the result to the C bus together with latched N/Z/carry flags. Shifts run serially, one bit per cycle, under a small FSM with valid/ready handshakes on both sides. A compile-time option replaces the serial path with a single-cycle barrel shift.

## Interface
- NBITS, 32 (shared definitions), datapath width; NBITS ≥ 16 required
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept a new operand
- alu_y  in  NBITS  ALU result
- alu_c  in  1  ALU carry-out
- sh_op  in  2  shift op: 00 NONE, 01 SLL8, 10 SRA1, 11 SRL1
- out_valid  out  1  c_bus and flags valid
- out_ready  in  1  consumer accepts result
- c_bus  out  NBITS  shifted result
- n_flag  out  1  MSB of final result
- z_flag  out  1  final result == 0
- carry_flag  out  1  alu_c captured at accept

## Operation
- A transfer occurs on a cycle where in_valid && in_ready. The stage captures alu_y into the work register, alu_c into carry_flag, and sets the step count: NONE=0, SRA1=1, SRL1=1, SLL8=8.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: out_valid=1.
- Transitions:
  - IDLE→DONE on accept with count 0; IDLE→SHIFT on accept with count >0.
  - SHIFT: shift the work register by one bit per cycle and decrement the count. Go to DONE on the cycle the last step is applied.
  - DONE→IDLE on out_ready with no new accept.
  - DONE→DONE or DONE→SHIFT on out_ready && in_valid (overlapped accept).
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Per-bit step:
  - SLL: shift left, fill 0.
  - SRA: shift right, replicate MSB.
  - SRL: shift right, fill 0.
- n_flag and z_flag are computed from the final result and registered when DONE is entered. carry_flag is not altered by the shift.
- While out_valid && !out_ready, c_bus and all flags hold stable.
- sh_op and alu_y are sampled only at accept; later changes on these inputs are ignored.
- Reset, asynchronous and also mid-shift: state=IDLE, c_bus=0, n_flag=0, z_flag=0, carry_flag=0, out_valid=0, count=0. Any in-flight operation is discarded.

## Timing
- Latency from accept to out_valid (serial build): NONE 1, SRA1/SRL1 2, SLL8 9 cycles.
- Throughput: one result per (latency) cycles. No bubble is inserted when the consumer accepts on the first DONE cycle.
- Outputs are driven from registers only; there is no combinational path from alu_y to c_bus.
- in_ready depends combinationally on out_ready, only in DONE.

## Configuration
- SHIFTER_BARREL_EN defined: the whole shift is applied in the accept cycle. The FSM never enters SHIFT, and every op has latency 1.
- SHIFTER_BARREL_EN undefined: serial shifter as described above, for minimum area.
- Results and flags are bit-identical in both builds; only latency differs.

## Structure
- Shared package shifter_pkg holds:
  - sh_op_e enum {SH_NONE, SH_SLL8, SH_SRA1, SH_SRL1}
  - state enum {ST_IDLE, ST_SHIFT, ST_DONE}
  - SLL8_STEPS = 8
  - step-count width constant (4 bits)
- One combinational sub-module, shift_unit, takes (value, sh_op, amount) and returns the shifted value. The serial build uses it with amount=1; the barrel build uses it with the full amount.

## Test plan
- Reset: assert rst_n=0 mid-cycle → all outputs 0 asynchronously, in_ready=1 after release.
- NONE: alu_y=0x8000_0000, alu_c=1 → one cycle later c_bus=0x8000_0000, n=1, z=0, carry=1.
- SLL8: alu_y=0x1234_5678 → c_bus=0x3456_7800 after 9 cycles (1 with SHIFTER_BARREL_EN); in_ready=0 throughout SHIFT.
- SRA1/SRL1: alu_y=0x8000_0001 → SRA1 gives 0xC000_0000 with n=1; SRL1 gives 0x4000_0000 with n=0. alu_y=0x0000_0001 with SRL1 → 0, z=1.
- Backpressure: out_ready=0 for 5 cycles in DONE → c_bus and flags stable, in_ready=0. Then out_ready=1 with in_valid=1 → overlapped accept, and the next result follows with no idle cycle.
- Reset mid-SLL8 after 4 steps → IDLE, out_valid never asserts for that operand; the next NONE op completes normally.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared definitions for the C-bus shifter stage.
// Optional build macro: SHIFTER_BARREL_EN (single-cycle barrel shift).
package shifter_pkg;

   localparam int NBITS      = 32;
   localparam int CNT_W      = 4;
   localparam int SLL8_STEPS = 8;

   typedef enum logic [1:0] {
      SH_NONE = 2'b00,
      SH_SLL8 = 2'b01,
      SH_SRA1 = 2'b10,
      SH_SRL1 = 2'b11
   } sh_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

   function automatic logic [CNT_W-1:0] steps_of(sh_op_e op);
      logic [CNT_W-1:0] s;
      unique case (op)
         SH_NONE: s = '0;
         SH_SLL8: s = CNT_W'(SLL8_STEPS);
         default: s = CNT_W'(1);
      endcase
      return s;
   endfunction

endpackage

// File: rtl/shifter_if.sv
// Handshake bundle between ALU, shifter stage and C-bus consumer.
// master: producer/consumer side, slave: the shifter stage.
interface shifter_if;
   import shifter_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [NBITS-1:0] alu_y;
   logic             alu_c;
   logic [1:0]       sh_op;
   logic             out_valid;
   logic             out_ready;
   logic [NBITS-1:0] c_bus;
   logic             n_flag;
   logic             z_flag;
   logic             carry_flag;

   modport master (
      output in_valid, alu_y, alu_c, sh_op, out_ready,
      input  in_ready, out_valid, c_bus,
      input  n_flag, z_flag, carry_flag
   );

   modport slave (
      input  in_valid, alu_y, alu_c, sh_op, out_ready,
      output in_ready, out_valid, c_bus,
      output n_flag, z_flag, carry_flag
   );

endinterface

// File: rtl/shifter_stage_shift_unit.sv
// Combinational shifter: applies sh_op to a value by a given amount.
// Serial build feeds amount 1; barrel build feeds the full count.
module shift_unit
   import shifter_pkg::*;
(
   input  logic [NBITS-1:0] val_i,
   input  sh_op_e           op_i,
   input  logic [CNT_W-1:0] amt_i,
   output logic [NBITS-1:0] res_o
);

   // Select the shift flavour; SRA replicates the sign bit.
   always_comb begin
      res_o = val_i;
      unique case (op_i)
         SH_NONE: res_o = val_i;
         SH_SLL8: res_o = val_i << amt_i;
         SH_SRA1: res_o = NBITS'($signed(val_i) >>> amt_i);
         SH_SRL1: res_o = val_i >> amt_i;
         default: res_o = val_i;
      endcase
   end

endmodule

// File: rtl/shifter_stage.sv
// Registered shifter stage between ALU and C bus.
// Macro SHIFTER_BARREL_EN selects the single-cycle barrel path.
module shifter_stage
   import shifter_pkg::*;
(
   input logic       clk,
   input logic       rst_n,
   shifter_if.slave  bus
);

   // NBITS must be at least 16 for SLL8 to be meaningful.

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NBITS-1:0] work_q, work_d;
   sh_op_e           op_q, op_d;
   logic             carry_q, carry_d;
   logic             n_q, n_d;
   logic             z_q, z_d;

   sh_op_e           op_in;
   logic             in_ready;
   logic             accept;
   logic [CNT_W-1:0] ld_cnt;
   logic [CNT_W-1:0] ld_cnt_eff;
   logic [NBITS-1:0] ld_val;
   logic [NBITS-1:0] step_val;

   logic [NBITS-1:0] su_val;
   sh_op_e           su_op;
   logic [CNT_W-1:0] su_amt;
   logic [NBITS-1:0] su_res;

   assign op_in  = sh_op_e'(bus.sh_op);
   assign ld_cnt = steps_of(op_in);

   assign in_ready = (state_q == ST_IDLE) ||
                     ((state_q == ST_DONE) && bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

`ifdef SHIFTER_BARREL_EN
   assign su_val     = bus.alu_y;
   assign su_op      = op_in;
   assign su_amt     = ld_cnt;
   assign ld_val     = su_res;
   assign ld_cnt_eff = '0;
   assign step_val   = work_q;
`else
   assign su_val     = work_q;
   assign su_op      = op_q;
   assign su_amt     = CNT_W'(1);
   assign ld_val     = bus.alu_y;
   assign ld_cnt_eff = ld_cnt;
   assign step_val   = su_res;
`endif

   shift_unit u_shift (
      .val_i (su_val),
      .op_i  (su_op),
      .amt_i (su_amt),
      .res_o (su_res)
   );

   // Next-state: accept/load, per-step shift, and result handoff.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      op_d    = op_q;
      carry_d = carry_q;
      n_d     = n_q;
      z_d     = z_q;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               work_d  = ld_val;
               op_d    = op_in;
               carry_d = bus.alu_c;
               cnt_d   = ld_cnt_eff;
               if (ld_cnt_eff == '0) begin
                  state_d = ST_DONE;
                  n_d     = ld_val[NBITS-1];
                  z_d     = (ld_val == '0);
               end else begin
                  state_d = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            work_d = step_val;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_DONE;
               n_d     = step_val[NBITS-1];
               z_d     = (step_val == '0);
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               if (bus.in_valid) begin
                  work_d  = ld_val;
                  op_d    = op_in;
                  carry_d = bus.alu_c;
                  cnt_d   = ld_cnt_eff;
                  if (ld_cnt_eff == '0) begin
                     state_d = ST_DONE;
                     n_d     = ld_val[NBITS-1];
                     z_d     = (ld_val == '0);
                  end else begin
                     state_d = ST_SHIFT;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any in-flight op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
         op_q    <= SH_NONE;
         carry_q <= 1'b0;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         op_q    <= op_d;
         carry_q <= carry_d;
         n_q     <= n_d;
         z_q     <= z_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = (state_q == ST_DONE);
   assign bus.c_bus      = work_q;
   assign bus.n_flag     = n_q;
   assign bus.z_flag     = z_q;
   assign bus.carry_flag = carry_q;

endmodule

// File: tb/tb_shifter_stage.sv
// Directed testbench for shifter_stage (serial or barrel build).
// Expected values are hand-computed constants.
module tb_shifter_stage;
   import shifter_pkg::*;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_pass;

   shifter_if bus ();

   shifter_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic int lat_of(input logic [1:0] op);
`ifdef SHIFTER_BARREL_EN
      return 1;
`else
      if (op == 2'b00) return 1;
      if (op == 2'b01) return 9;
      return 2;
`endif
   endfunction

   task automatic do_op(input string tag,
                        input logic [1:0] op,
                        input logic [31:0] y,
                        input logic c,
                        input logic [31:0] ey,
                        input logic en,
                        input logic ez);
      int lat;
      logic bad;
      @(negedge clk);
      check({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.alu_y    = y;
      bus.alu_c    = c;
      bus.sh_op    = op;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.alu_y    = ~y;
      bus.alu_c    = ~c;
      bus.sh_op    = ~op;
      lat = 0;
      bad = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (!bus.out_valid && bus.in_ready) bad = 1'b1;
      end while (!bus.out_valid && lat < 20);
      check({tag, "_lat"}, 64'(lat), 64'(lat_of(op)));
      check({tag, "_cbus"}, 64'(bus.c_bus), 64'(ey));
      check({tag, "_n"}, 64'(bus.n_flag), 64'(en));
      check({tag, "_z"}, 64'(bus.z_flag), 64'(ez));
      check({tag, "_c"}, 64'(bus.carry_flag), 64'(c));
      check({tag, "_busy"}, 64'(bad), 64'd0);
   endtask

   task automatic pop();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] sv_bus;
      logic [2:0]  sv_fl;
      logic        bad;
      logic        seen;
      n_chk = 0;
      n_pass = 0;
      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.alu_y     = '0;
      bus.alu_c     = 1'b0;
      bus.sh_op     = 2'b00;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ov", 64'(bus.out_valid), 64'd0);
      check("rst_cbus", 64'(bus.c_bus), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_rdy", 64'(bus.in_ready), 64'd1);

      do_op("none", 2'b00, 32'h8000_0000, 1'b1,
            32'h8000_0000, 1'b1, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      check("arst_ov", 64'(bus.out_valid), 64'd0);
      check("arst_cbus", 64'(bus.c_bus), 64'd0);
      check("arst_n", 64'(bus.n_flag), 64'd0);
      check("arst_c", 64'(bus.carry_flag), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("arst_rdy", 64'(bus.in_ready), 64'd1);

      do_op("sll8", 2'b01, 32'h1234_5678, 1'b1,
            32'h3456_7800, 1'b0, 1'b0);
      pop();
      do_op("sra1", 2'b10, 32'h8000_0001, 1'b0,
            32'hC000_0000, 1'b1, 1'b0);
      pop();
      do_op("srl1", 2'b11, 32'h8000_0001, 1'b1,
            32'h4000_0000, 1'b0, 1'b0);
      pop();
      do_op("srl1z", 2'b11, 32'h0000_0001, 1'b0,
            32'h0000_0000, 1'b0, 1'b1);
      pop();

      do_op("bp", 2'b11, 32'h8000_0001, 1'b0,
            32'h4000_0000, 1'b0, 1'b0);
      sv_bus = bus.c_bus;
      sv_fl  = {bus.n_flag, bus.z_flag, bus.carry_flag};
      bad = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (bus.c_bus !== sv_bus) bad = 1'b1;
         if ({bus.n_flag, bus.z_flag, bus.carry_flag} !== sv_fl)
            bad = 1'b1;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
            bad = 1'b1;
      end
      check("bp_stable", 64'(bad), 64'd0);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.alu_y     = 32'h0;
      bus.alu_c     = 1'b0;
      bus.sh_op     = 2'b00;
      #1;
      check("ovl_rdy", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.alu_y     = 32'hFFFF_FFFF;
      @(negedge clk);
      check("ovl_ov", 64'(bus.out_valid), 64'd1);
      check("ovl_cbus", 64'(bus.c_bus), 64'd0);
      check("ovl_z", 64'(bus.z_flag), 64'd1);
      check("ovl_c", 64'(bus.carry_flag), 64'd0);
      pop();

      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.alu_y    = 32'h1234_5678;
      bus.alu_c    = 1'b1;
      bus.sh_op    = 2'b01;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_ov", 64'(bus.out_valid), 64'd0);
      check("mid_cbus", 64'(bus.c_bus), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      check("mid_nov", 64'(seen), 64'd0);
      do_op("post", 2'b00, 32'h0000_00A5, 1'b0,
            32'h0000_00A5, 1'b0, 1'b0);
      pop();

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
